// File: rtl/bin_level_sensor.sv
// bin_level_sensor: ultrasonic ranger front end for one bin.
// Fires a trigger pulse, times the synchronized echo width in prescaled ticks,
// converts distance to fill capacity (short echo = full) and smooths the result
// with a 4-sample moving average.
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   enable       run periodic measurements while high
//   echo         asynchronous echo input from the ranger
//   trig         trigger pulse to the ranger
//   bin_cap      averaged capacity, 0 = empty, 255 = full
//   cap_valid    one-cycle pulse when bin_cap updates
//   bin_full     high while bin_cap >= FULL_LEVEL
//   sensor_fault sticky timeout flag, cleared by the next good measurement
module bin_level_sensor #(
   parameter int unsigned PRESCALE       = 4,
   parameter int unsigned TRIG_CYCLES    = 10,
   parameter int unsigned TIMEOUT_CYCLES = 2048,
   parameter int unsigned HOLDOFF_CYCLES = 100,
   parameter int unsigned FULL_LEVEL     = 230
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       echo,
   output logic       trig,
   output logic [7:0] bin_cap,
   output logic       cap_valid,
   output logic       bin_full,
   output logic       sensor_fault
);

   localparam int unsigned CAP_W     = 8;
   localparam int unsigned SUM_W     = 10;
   localparam int unsigned HIST_N    = 4;
   localparam int unsigned CNT_MAX_A = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > TRIG_CYCLES) ? CNT_MAX_A : TRIG_CYCLES;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_ECHO = 3'd2,
      S_MEASURE   = 3'd3,
      S_DONE      = 3'd4,
      S_HOLDOFF   = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [CAP_W-1:0]   ticks_q, ticks_d;
   logic [CAP_W-1:0]   hist_q [HIST_N];
   logic [CAP_W-1:0]   hist_d [HIST_N];
   logic               hist_valid_q, hist_valid_d;
   logic [CAP_W-1:0]   bin_cap_q, bin_cap_d;
   logic               bin_full_q, bin_full_d;
   logic               cap_valid_q, cap_valid_d;
   logic               fault_q, fault_d;
   logic               trig_q, trig_d;
   logic               echo_meta_q, echo_meta_d;
   logic               echo_s_q, echo_s_d;

   // Scratch values for the per-cycle echo count and the averaging update
   logic [PRE_W-1:0]   pre_base, pre_step;
   logic [CAP_W-1:0]   ticks_base, ticks_step;
   logic [CAP_W-1:0]   raw;
   logic [SUM_W-1:0]   sum;

   assign trig         = trig_q;
   assign bin_cap      = bin_cap_q;
   assign cap_valid    = cap_valid_q;
   assign bin_full     = bin_full_q;
   assign sensor_fault = fault_q;

   // Next-state, counters, averaging and outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pre_d        = pre_q;
      ticks_d      = ticks_q;
      hist_d       = hist_q;
      hist_valid_d = hist_valid_q;
      bin_cap_d    = bin_cap_q;
      bin_full_d   = bin_full_q;
      cap_valid_d  = 1'b0;
      fault_d      = fault_q;
      echo_meta_d  = echo;
      echo_s_d     = echo_meta_q;
      trig_d       = (state_q == S_TRIG);
      raw          = '0;
      sum          = '0;

      // One echo-high cycle of counting; the detecting WAIT_ECHO cycle starts from zero
      pre_base   = (state_q == S_WAIT_ECHO) ? '0 : pre_q;
      ticks_base = (state_q == S_WAIT_ECHO) ? '0 : ticks_q;
      if (pre_base == PRE_W'(PRESCALE - 1)) begin
         pre_step   = '0;
         ticks_step = (ticks_base == 8'hFF) ? 8'hFF : ticks_base + 8'd1;
      end else begin
         pre_step   = pre_base + PRE_W'(1);
         ticks_step = ticks_base;
      end

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_TRIG;
               cnt_d   = '0;
            end
         end
         S_TRIG: begin
            if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
               state_d = S_WAIT_ECHO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_ECHO: begin
            if (echo_s_q) begin
               state_d = S_MEASURE;
               cnt_d   = '0;
               pre_d   = pre_step;
               ticks_d = ticks_step;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_HOLDOFF;
               cnt_d   = '0;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_MEASURE: begin
            if (!echo_s_q) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_HOLDOFF;
               cnt_d   = '0;
               fault_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               pre_d   = pre_step;
               ticks_d = ticks_step;
            end
         end
         S_DONE: begin
            // Long echo means far surface, i.e. an emptier bin
            raw = 8'hFF - ticks_q;
            if (!hist_valid_q) begin
               for (int i = 0; i < HIST_N; i++) hist_d[i] = raw;
            end else begin
               hist_d[0] = raw;
               for (int i = 1; i < HIST_N; i++) hist_d[i] = hist_q[i-1];
            end
            sum = SUM_W'(hist_d[0]) + SUM_W'(hist_d[1]) + SUM_W'(hist_d[2]) + SUM_W'(hist_d[3]);
            bin_cap_d    = sum[SUM_W-1:2];
            bin_full_d   = (sum[SUM_W-1:2] >= CAP_W'(FULL_LEVEL));
            cap_valid_d  = 1'b1;
            fault_d      = 1'b0;
            hist_valid_d = 1'b1;
            state_d      = S_HOLDOFF;
            cnt_d        = '0;
         end
         S_HOLDOFF: begin
            if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
               state_d = enable ? S_TRIG : S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         pre_q        <= '0;
         ticks_q      <= '0;
         for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
         hist_valid_q <= 1'b0;
         bin_cap_q    <= '0;
         bin_full_q   <= 1'b0;
         cap_valid_q  <= 1'b0;
         fault_q      <= 1'b0;
         trig_q       <= 1'b0;
         echo_meta_q  <= 1'b0;
         echo_s_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pre_q        <= pre_d;
         ticks_q      <= ticks_d;
         for (int i = 0; i < HIST_N; i++) hist_q[i] <= hist_d[i];
         hist_valid_q <= hist_valid_d;
         bin_cap_q    <= bin_cap_d;
         bin_full_q   <= bin_full_d;
         cap_valid_q  <= cap_valid_d;
         fault_q      <= fault_d;
         trig_q       <= trig_d;
         echo_meta_q  <= echo_meta_d;
         echo_s_q     <= echo_s_d;
      end
   end

endmodule

// File: tb/tb_bin_level_sensor.sv
// tb_bin_level_sensor: directed scenarios for bin_level_sensor with default parameters.
module tb_bin_level_sensor;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       echo;
   logic       trig;
   logic [7:0] bin_cap;
   logic       cap_valid;
   logic       bin_full;
   logic       sensor_fault;

   int n_cmp = 0;
   int n_bad = 0;

   bin_level_sensor dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .echo         (echo),
      .trig         (trig),
      .bin_cap      (bin_cap),
      .cap_valid    (cap_valid),
      .bin_full     (bin_full),
      .sensor_fault (sensor_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Holds echo high for len rising edges
   task automatic drive_echo(input int len);
      echo = 1'b1;
      repeat (len) @(negedge clk);
      echo = 1'b0;
   endtask

   // Waits for a full trigger pulse (rise then fall)
   task automatic wait_trig_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (trig) begin ok = 1'b1; break; end
      end
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!trig) begin ok = 1'b1; break; end
         end
      end
   endtask

   // Waits for the cap_valid pulse; leaves the bench at the pulse cycle
   task automatic wait_cap(output bit got);
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (cap_valid) begin got = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b0; echo = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (trig !== 1'b0) begin n_bad++; $display("FAIL reset_trig: got %b expected 0", trig); end
      n_cmp++; if (bin_cap !== 8'd0) begin n_bad++; $display("FAIL reset_bin_cap: got %0d expected 0", bin_cap); end
      n_cmp++; if (cap_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cap_valid: got %b expected 0", cap_valid); end
      n_cmp++; if (bin_full !== 1'b0) begin n_bad++; $display("FAIL reset_bin_full: got %b expected 0", bin_full); end
      n_cmp++; if (sensor_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b expected 0", sensor_fault); end
   endtask

   task automatic test_trig_pulse();
      int hi;
      rst = 1'b1; enable = 1'b1;
      @(negedge clk);
      n_cmp++; if (trig !== 1'b0) begin n_bad++; $display("FAIL trig_early: got %b expected 0", trig); end
      @(negedge clk);
      n_cmp++; if (trig !== 1'b1) begin n_bad++; $display("FAIL trig_start: got %b expected 1", trig); end
      hi = (trig === 1'b1) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (trig === 1'b1) hi++;
         else break;
      end
      n_cmp++; if (hi != 10) begin n_bad++; $display("FAIL trig_width: got %0d expected 10", hi); end
   endtask

   task automatic test_first_sample();
      bit got;
      repeat (3) @(negedge clk);
      drive_echo(40);
      wait_cap(got);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL s1_cap_valid: got 0 expected 1"); end
      n_cmp++; if (bin_cap !== 8'd245) begin n_bad++; $display("FAIL s1_bin_cap: got %0d expected 245", bin_cap); end
      n_cmp++; if (bin_full !== 1'b1) begin n_bad++; $display("FAIL s1_bin_full: got %b expected 1", bin_full); end
      @(negedge clk);
      n_cmp++; if (cap_valid !== 1'b0) begin n_bad++; $display("FAIL s1_pulse_width: got %b expected 0", cap_valid); end
   endtask

   task automatic test_second_sample();
      bit ok, got;
      wait_trig_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL s2_trig: got 0 expected 1"); end
      repeat (3) @(negedge clk);
      drive_echo(400);
      wait_cap(got);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL s2_cap_valid: got 0 expected 1"); end
      n_cmp++; if (bin_cap !== 8'd222) begin n_bad++; $display("FAIL s2_bin_cap: got %0d expected 222", bin_cap); end
      n_cmp++; if (bin_full !== 1'b0) begin n_bad++; $display("FAIL s2_bin_full: got %b expected 0", bin_full); end
   endtask

   task automatic test_saturation();
      bit ok, got;
      wait_trig_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL sat_trig: got 0 expected 1"); end
      repeat (3) @(negedge clk);
      drive_echo(1500);
      wait_cap(got);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL sat_cap_valid: got 0 expected 1"); end
      n_cmp++; if (bin_cap !== 8'd161) begin n_bad++; $display("FAIL sat_bin_cap: got %0d expected 161", bin_cap); end
      n_cmp++; if (sensor_fault !== 1'b0) begin n_bad++; $display("FAIL sat_fault: got %b expected 0", sensor_fault); end
   endtask

   task automatic test_timeout();
      bit ok, seen_fault;
      int pulses;
      wait_trig_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_trig: got 0 expected 1"); end
      pulses = 0;
      repeat (2040) begin
         @(negedge clk);
         if (cap_valid === 1'b1) pulses++;
      end
      n_cmp++; if (sensor_fault !== 1'b0) begin n_bad++; $display("FAIL to_early_fault: got %b expected 0", sensor_fault); end
      seen_fault = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (cap_valid === 1'b1) pulses++;
         if (sensor_fault === 1'b1) begin seen_fault = 1'b1; break; end
      end
      n_cmp++; if (!seen_fault) begin n_bad++; $display("FAIL to_fault: got 0 expected 1"); end
      n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL to_no_valid: got %0d pulses expected 0", pulses); end
      n_cmp++; if (bin_cap !== 8'd161) begin n_bad++; $display("FAIL to_bin_cap: got %0d expected 161", bin_cap); end
   endtask

   task automatic test_recovery();
      bit ok, got;
      wait_trig_done(ok);
      n_cmp++; if (sensor_fault !== 1'b1) begin n_bad++; $display("FAIL rec_sticky: got %b expected 1", sensor_fault); end
      repeat (3) @(negedge clk);
      drive_echo(40);
      wait_cap(got);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL rec_cap_valid: got 0 expected 1"); end
      n_cmp++; if (sensor_fault !== 1'b0) begin n_bad++; $display("FAIL rec_fault_clr: got %b expected 0", sensor_fault); end
      n_cmp++; if (bin_cap !== 8'd161) begin n_bad++; $display("FAIL rec_bin_cap: got %0d expected 161", bin_cap); end
      wait_trig_done(ok);
      repeat (3) @(negedge clk);
      drive_echo(80);
      wait_cap(got);
      n_cmp++; if (bin_cap !== 8'd158) begin n_bad++; $display("FAIL rec2_bin_cap: got %0d expected 158", bin_cap); end
      n_cmp++; if (bin_full !== 1'b0) begin n_bad++; $display("FAIL rec2_bin_full: got %b expected 0", bin_full); end
   endtask

   task automatic test_reset_mid();
      bit ok, got;
      wait_trig_done(ok);
      repeat (3) @(negedge clk);
      echo = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (trig !== 1'b0) begin n_bad++; $display("FAIL mid_trig: got %b expected 0", trig); end
      n_cmp++; if (bin_cap !== 8'd0) begin n_bad++; $display("FAIL mid_bin_cap: got %0d expected 0", bin_cap); end
      n_cmp++; if (bin_full !== 1'b0) begin n_bad++; $display("FAIL mid_bin_full: got %b expected 0", bin_full); end
      echo = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_trig_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_restart_trig: got 0 expected 1"); end
      repeat (3) @(negedge clk);
      drive_echo(80);
      wait_cap(got);
      n_cmp++; if (bin_cap !== 8'd235) begin n_bad++; $display("FAIL mid_reload: got %0d expected 235", bin_cap); end
      n_cmp++; if (bin_full !== 1'b1) begin n_bad++; $display("FAIL mid_bin_full2: got %b expected 1", bin_full); end
   endtask

   task automatic test_enable_drop();
      int trigs, pulses;
      @(negedge clk);
      enable = 1'b0;
      trigs = 0; pulses = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (trig === 1'b1) trigs++;
         if (cap_valid === 1'b1) pulses++;
         if (i == 200) echo = 1'b1;
         if (i == 240) echo = 1'b0;
      end
      n_cmp++; if (trigs != 0) begin n_bad++; $display("FAIL en_no_trig: got %0d trig cycles expected 0", trigs); end
      n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL en_echo_ignored: got %0d pulses expected 0", pulses); end
      n_cmp++; if (bin_cap !== 8'd235) begin n_bad++; $display("FAIL en_bin_cap: got %0d expected 235", bin_cap); end
   endtask

   initial begin
      test_reset();
      test_trig_pulse();
      test_first_sample();
      test_second_sample();
      test_saturation();
      test_timeout();
      test_recovery();
      test_reset_mid();
      test_enable_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
